// File: rtl/pipeline_stall_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: state encoding,
// register-address width and counter widths.
package pipeline_stall_ctrl_pkg;

  localparam int unsigned STATE_W     = 2;
  localparam int unsigned REG_ADDR_W  = 3;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned MEM_CNT_W   = 16;
  localparam int unsigned FLUSH_CNT_W = 4;

  typedef enum logic [STATE_W-1:0] {
    RUN        = 2'd0,
    LOAD_STALL = 2'd1,
    MEM_WAIT   = 2'd2,
    FLUSH      = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_stall_ctrl_load_use_detect.sv
// Load-use hazard detector: flags a decode instruction that reads the register
// a load in execute is about to write.
//   src1_i, src2_i         decode source register addresses
//   src1_used_i, src2_used_i  decode instruction reads that source
//   dest_i                 destination register of the execute instruction
//   rw_i, mtr_i            execute instruction writes a register / is a load
//   load_use_o             hazard present (combinational)
module pipeline_stall_ctrl_load_use_detect
  import pipeline_stall_ctrl_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] src1_i,
  input  logic [REG_ADDR_W-1:0] src2_i,
  input  logic                  src1_used_i,
  input  logic                  src2_used_i,
  input  logic [REG_ADDR_W-1:0] dest_i,
  input  logic                  rw_i,
  input  logic                  mtr_i,
  output logic                  load_use_o
);

  logic src1_hit;
  logic src2_hit;

  assign src1_hit   = src1_used_i && (src1_i == dest_i);
  assign src2_hit   = src2_used_i && (src2_i == dest_i);
  assign load_use_o = mtr_i && rw_i && (src1_hit || src2_hit);

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. Produces PC/F2D/D2E/E2M
// load enables and F2D/D2E flush strobes for load-use, taken-branch redirect
// and multi-cycle data-memory access. Strobes are Mealy (state + inputs).
//   clk, rst                       clock, async active-high reset
//   src1_d, src2_d, src*_used_d    decode sources
//   destAddrAfterD2E, RWAfterD2E, MTRAfterD2E  execute-stage control
//   branch_taken_e                 taken branch resolved in execute
//   mem_req_m, mem_ready           memory-stage access / completion
//   pc_en, f2d_en, d2e_en, e2m_en  register load enables
//   f2d_flush, d2e_flush           bubble insertion
//   mem_err                        one-cycle pulse on memory timeout
//   stall_cycles                   stall-cycle counter
// Optional feature macro: PIPELINE_STALL_PERF_CNT_EN enables stall_cycles;
// otherwise it is tied to zero.
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT  = 255,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [REG_ADDR_W-1:0]  src1_d,
  input  logic [REG_ADDR_W-1:0]  src2_d,
  input  logic                   src1_used_d,
  input  logic                   src2_used_d,
  input  logic [REG_ADDR_W-1:0]  destAddrAfterD2E,
  input  logic                   RWAfterD2E,
  input  logic                   MTRAfterD2E,
  input  logic                   branch_taken_e,
  input  logic                   mem_req_m,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   f2d_en,
  output logic                   d2e_en,
  output logic                   e2m_en,
  output logic                   f2d_flush,
  output logic                   d2e_flush,
  output logic                   mem_err,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam bit                   MULTI_FLUSH = (FLUSH_CYCLES > 1);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD =
    MULTI_FLUSH ? FLUSH_CNT_W'(FLUSH_CYCLES - 1) : '0;
  localparam logic [MEM_CNT_W-1:0] MEM_LIMIT = MEM_CNT_W'(MEM_TIMEOUT);

  state_e                 state_q, state_d;
  logic [MEM_CNT_W-1:0]   mem_cnt_q, mem_cnt_d;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic load_use_c;
  logic mem_stall_c;
  logic pc_en_c, f2d_en_c, d2e_en_c, e2m_en_c;
  logic f2d_flush_c, d2e_flush_c, mem_err_c;

  pipeline_stall_ctrl_load_use_detect u_load_use_detect (
    .src1_i      (src1_d),
    .src2_i      (src2_d),
    .src1_used_i (src1_used_d),
    .src2_used_i (src2_used_d),
    .dest_i      (destAddrAfterD2E),
    .rw_i        (RWAfterD2E),
    .mtr_i       (MTRAfterD2E),
    .load_use_o  (load_use_c)
  );

  assign mem_stall_c = mem_req_m && !mem_ready;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      mem_cnt_q   <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_cnt_q   <= mem_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Next state and strobes, in event priority: timeout/mem stall, branch, load-use
  always_comb begin
    state_d     = state_q;
    mem_cnt_d   = mem_cnt_q;
    flush_cnt_d = flush_cnt_q;
    pc_en_c     = 1'b1;
    f2d_en_c    = 1'b1;
    d2e_en_c    = 1'b1;
    e2m_en_c    = 1'b1;
    f2d_flush_c = 1'b0;
    d2e_flush_c = 1'b0;
    mem_err_c   = 1'b0;

    if (state_q == MEM_WAIT && mem_stall_c && mem_cnt_q == MEM_LIMIT) begin
      // Forced release: default strobes with an error pulse
      mem_err_c = 1'b1;
      mem_cnt_d = '0;
      state_d   = RUN;
    end else if (mem_stall_c) begin
      // Counter holds the number of frozen cycles seen so far
      pc_en_c   = 1'b0;
      f2d_en_c  = 1'b0;
      d2e_en_c  = 1'b0;
      e2m_en_c  = 1'b0;
      mem_cnt_d = MEM_CNT_W'(mem_cnt_q + 1'b1);
      state_d   = MEM_WAIT;
    end else begin
      mem_cnt_d = '0;
      if (branch_taken_e) begin
        f2d_flush_c = 1'b1;
        d2e_flush_c = 1'b1;
        flush_cnt_d = FLUSH_RELOAD;
        state_d     = MULTI_FLUSH ? FLUSH : RUN;
      end else begin
        case (state_q)
          FLUSH: begin
            f2d_flush_c = 1'b1;
            flush_cnt_d = FLUSH_CNT_W'(flush_cnt_q - 1'b1);
            state_d     = (flush_cnt_q <= FLUSH_CNT_W'(1)) ? RUN : FLUSH;
          end
          LOAD_STALL: begin
            state_d = RUN;
          end
          default: begin
            // RUN, and the MEM_WAIT release cycle, which behaves as RUN
            if (load_use_c) begin
              pc_en_c     = 1'b0;
              f2d_en_c    = 1'b0;
              d2e_flush_c = 1'b1;
              state_d     = LOAD_STALL;
            end else begin
              state_d = RUN;
            end
          end
        endcase
      end
    end
  end

  // Everything is held quiet while reset is asserted
  assign pc_en     = pc_en_c     && !rst;
  assign f2d_en    = f2d_en_c    && !rst;
  assign d2e_en    = d2e_en_c    && !rst;
  assign e2m_en    = e2m_en_c    && !rst;
  assign f2d_flush = f2d_flush_c && !rst;
  assign d2e_flush = d2e_flush_c && !rst;
  assign mem_err   = mem_err_c   && !rst;

`ifdef PIPELINE_STALL_PERF_CNT_EN
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles with the PC held
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!pc_en_c && stall_cnt_q != '1) begin
      stall_cnt_d = STALL_CNT_W'(stall_cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: directed vector table for the multi-cycle
// sequences, then random traffic checked against a behavioural model.
module tb_pipeline_stall_ctrl;

  localparam int unsigned MEM_TIMEOUT  = 4;
  localparam int unsigned FLUSH_CYCLES = 2;

  // Strobe vector order: {pc, f2d, d2e, e2m, f2d_flush, d2e_flush, mem_err}
  localparam logic [6:0] S_RST = 7'b0000000;
  localparam logic [6:0] S_DEF = 7'b1111000;
  localparam logic [6:0] S_FRZ = 7'b0000000;
  localparam logic [6:0] S_LU  = 7'b0011010;
  localparam logic [6:0] S_BR  = 7'b1111110;
  localparam logic [6:0] S_FL  = 7'b1111100;
  localparam logic [6:0] S_ERR = 7'b1111001;

  typedef struct {
    logic       rst;
    logic [2:0] s1;
    logic [2:0] s2;
    logic [2:0] dest;
    logic       u1;
    logic       u2;
    logic       rw;
    logic       mtr;
    logic       br;
    logic       req;
    logic       rdy;
    logic [6:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  src1_d = '0, src2_d = '0, dest = '0;
  logic        src1_used_d = 1'b0, src2_used_d = 1'b0;
  logic        rw = 1'b0, mtr = 1'b0, br = 1'b0, req = 1'b0, rdy = 1'b0;
  logic        pc_en, f2d_en, d2e_en, e2m_en, f2d_flush, d2e_flush, mem_err;
  logic [15:0] stall_cycles;

  int n_pass  = 0;
  int n_total = 0;

  // Model state: remaining F2D flush cycles, consecutive frozen cycles,
  // whether the last cycle inserted a load-use bubble, stall counter.
  int          m_flush_left = 0;
  int          m_wait       = 0;
  bit          m_bubble     = 1'b0;
  logic [15:0] m_stall_cnt  = '0;

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .FLUSH_CYCLES (FLUSH_CYCLES)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .src1_d           (src1_d),
    .src2_d           (src2_d),
    .src1_used_d      (src1_used_d),
    .src2_used_d      (src2_used_d),
    .destAddrAfterD2E (dest),
    .RWAfterD2E       (rw),
    .MTRAfterD2E      (mtr),
    .branch_taken_e   (br),
    .mem_req_m        (req),
    .mem_ready        (rdy),
    .pc_en            (pc_en),
    .f2d_en           (f2d_en),
    .d2e_en           (d2e_en),
    .e2m_en           (e2m_en),
    .f2d_flush        (f2d_flush),
    .d2e_flush        (d2e_flush),
    .mem_err          (mem_err),
    .stall_cycles     (stall_cycles)
  );

  always #5 clk = ~clk;

  // hz: 0 none, 1 src1 hit, 2 src2 hit, 3 src1 match but unused, 4 no RW, 5 no MTR
  function automatic vec_t mk(input logic r, input logic b, input logic q,
                              input logic d, input int hz, input logic [6:0] e);
    vec_t t;
    t.rst = r; t.br = b; t.req = q; t.rdy = d; t.exp = e;
    t.s1 = 3'd1; t.s2 = 3'd4; t.dest = 3'd2;
    t.u1 = 1'b1; t.u2 = 1'b1; t.rw = 1'b1; t.mtr = 1'b1;
    case (hz)
      1: t.s1 = 3'd2;
      2: begin t.s1 = 3'd5; t.s2 = 3'd2; end
      3: begin t.s1 = 3'd2; t.u1 = 1'b0; end
      4: begin t.s1 = 3'd2; t.rw = 1'b0; end
      5: begin t.s1 = 3'd2; t.mtr = 1'b0; end
      default: ;
    endcase
    return t;
  endfunction

  // Behavioural model: expected strobes for this cycle, then advance one cycle.
  function automatic logic [6:0] model_step(input vec_t t);
    logic [6:0] e;
    bit stall, hazard;
    if (t.rst) begin
      m_flush_left = 0; m_wait = 0; m_bubble = 1'b0; m_stall_cnt = '0;
      return S_RST;
    end
    stall  = t.req && !t.rdy;
    hazard = t.mtr && t.rw && ((t.u1 && t.s1 == t.dest) || (t.u2 && t.s2 == t.dest));
    if (stall && m_wait == int'(MEM_TIMEOUT)) begin
      e = S_ERR; m_wait = 0; m_flush_left = 0; m_bubble = 1'b0;
    end else if (stall) begin
      e = S_FRZ; m_wait++; m_flush_left = 0; m_bubble = 1'b0;
    end else begin
      m_wait = 0;
      if (t.br) begin
        e = S_BR; m_flush_left = int'(FLUSH_CYCLES) - 1; m_bubble = 1'b0;
      end else if (m_flush_left > 0) begin
        e = S_FL; m_flush_left--; m_bubble = 1'b0;
      end else if (!m_bubble && hazard) begin
        e = S_LU; m_bubble = 1'b1;
      end else begin
        e = S_DEF; m_bubble = 1'b0;
      end
    end
`ifdef PIPELINE_STALL_PERF_CNT_EN
    if (!e[6] && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
`endif
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // One clock cycle: drive at negedge, compare mid-cycle, model advances.
  task automatic apply(input vec_t t, input bit use_tbl, input string name);
    logic [6:0]  e_model;
    logic [15:0] e_cnt;
    @(negedge clk);
    rst = t.rst; src1_d = t.s1; src2_d = t.s2; dest = t.dest;
    src1_used_d = t.u1; src2_used_d = t.u2; rw = t.rw; mtr = t.mtr;
    br = t.br; req = t.req; rdy = t.rdy;
    #1;
    e_cnt   = t.rst ? 16'd0 : m_stall_cnt;
    e_model = model_step(t);
    check({name, "_strobes"},
          32'({pc_en, f2d_en, d2e_en, e2m_en, f2d_flush, d2e_flush, mem_err}),
          32'(use_tbl ? t.exp : e_model));
    check({name, "_stall_cycles"}, 32'(stall_cycles), 32'(e_cnt));
  endtask

  vec_t tbl[$];
  vec_t rv;

  initial begin
    // reset and idle
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RST));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // load-use on src1: one bubble, then LOAD_STALL suppresses, then RUN
    tbl.push_back(mk(0, 0, 0, 0, 1, S_LU));
    tbl.push_back(mk(0, 0, 0, 0, 1, S_DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // load-use on src2, and the three non-hazard qualifiers
    tbl.push_back(mk(0, 0, 0, 0, 2, S_LU));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    tbl.push_back(mk(0, 0, 0, 0, 3, S_DEF));
    tbl.push_back(mk(0, 0, 0, 0, 4, S_DEF));
    tbl.push_back(mk(0, 0, 0, 0, 5, S_DEF));
    // taken branch: two F2D flush cycles, one D2E flush
    tbl.push_back(mk(0, 1, 0, 0, 0, S_BR));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_FL));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // branch + load-use together: branch wins, no LOAD_STALL, FLUSH ignores hazard
    tbl.push_back(mk(0, 1, 0, 0, 1, S_BR));
    tbl.push_back(mk(0, 0, 0, 0, 1, S_FL));
    tbl.push_back(mk(0, 0, 0, 0, 1, S_LU));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // branch during FLUSH reloads the flush counter
    tbl.push_back(mk(0, 1, 0, 0, 0, S_BR));
    tbl.push_back(mk(0, 1, 0, 0, 0, S_BR));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_FL));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // memory wait of 3 cycles then ready
    repeat (3) tbl.push_back(mk(0, 0, 1, 0, 0, S_FRZ));
    tbl.push_back(mk(0, 0, 1, 1, 0, S_DEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // ready arriving exactly at the timeout limit: no error
    repeat (4) tbl.push_back(mk(0, 0, 1, 0, 0, S_FRZ));
    tbl.push_back(mk(0, 0, 1, 1, 0, S_DEF));
    // timeout: 4 frozen cycles, error on the 5th, then RUN
    repeat (4) tbl.push_back(mk(0, 0, 1, 0, 0, S_FRZ));
    tbl.push_back(mk(0, 0, 1, 0, 0, S_ERR));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // branch held across a memory stall, serviced on release
    repeat (2) tbl.push_back(mk(0, 1, 1, 0, 0, S_FRZ));
    tbl.push_back(mk(0, 1, 1, 1, 0, S_BR));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_FL));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // reset mid-MEM_WAIT, then a fresh stall
    repeat (2) tbl.push_back(mk(0, 0, 1, 0, 0, S_FRZ));
    tbl.push_back(mk(1, 0, 1, 0, 0, S_RST));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    tbl.push_back(mk(0, 0, 1, 0, 0, S_FRZ));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));
    // reset mid-FLUSH aborts the flush
    tbl.push_back(mk(0, 1, 0, 0, 0, S_BR));
    tbl.push_back(mk(1, 0, 0, 0, 0, S_RST));
    tbl.push_back(mk(0, 0, 0, 0, 0, S_DEF));

    foreach (tbl[i]) apply(tbl[i], 1'b1, $sformatf("vec%0d", i));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rv = mk(0, 0, 0, 0, 0, S_DEF);
      rv.rst  = ($urandom_range(99) < 2);
      rv.s1   = 3'($urandom_range(7));
      rv.s2   = 3'($urandom_range(7));
      rv.dest = 3'($urandom_range(3));
      rv.u1   = 1'($urandom_range(1));
      rv.u2   = 1'($urandom_range(1));
      rv.rw   = ($urandom_range(99) < 80);
      rv.mtr  = ($urandom_range(99) < 50);
      rv.br   = ($urandom_range(99) < 12);
      rv.req  = ($urandom_range(99) < 35);
      rv.rdy  = ($urandom_range(99) < 35);
      apply(rv, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
